clarvi_reg_writeback: RTL
=========================

// Module: clarvi_reg_writeback
// PURPOSE
//  Write-side sequencer for the 64-bit register file, whose write port takes one 32-bit half per cycle.
//  Accepts a whole 64-bit result (register index, data, half mask) from execute/memory over valid/ready.
//  Drives the file's write port (part/register/data/enable) as 1-2 half-word writes, low half first.
//  Suppresses writes to x0; pulses done when an entry retires.
// PARAMETERS
//  (none; widths fixed: 5-bit index, 64-bit data, 32-bit write port)
// PORTS
//  clock          in   1   single clock, rising edge
//  reset_n        in   1   asynchronous, active-low reset
//  in_valid       in   1   result offered
//  in_ready       out  1   result accepted on in_valid && in_ready
//  in_register    in   5   destination register index
//  in_data        in   64  result value
//  in_part_mask   in   2   bit0 = write [31:0], bit1 = write [63:32]
//  wb_enable      out  1   write strobe to register file
//  wb_part        out  1   0 = low half, 1 = high half
//  wb_register    out  5   write register index
//  wb_data        out  32  half-word being written
//  wb_done        out  1   one-cycle pulse: entry fully retired this cycle
// BEHAVIOUR
//  - Holding entry: hold_register[4:0], hold_data[63:0], pend[1:0] (pending halves), hold_valid.
//  - Accept: mask forced to 2'b00 when in_register == 0. Entry loaded on the edge; pend = effective mask.
//  - Emission: combinational from the holding entry, in the cycle after accept.
//    pend[0] set -> wb_part = 0, wb_data = hold_data[31:0];
//    else pend[1] set -> wb_part = 1, wb_data = hold_data[63:32].
//    wb_enable = hold_valid && |pend. The emitted bit is cleared at the edge.
//  - Last cycle: pend has at most one bit set. wb_done = hold_valid && last cycle, and hold_valid clears
//    unless a new entry is accepted on the same edge.
//  - Null entry: mask 00 or x0 occupies exactly one cycle, wb_enable = 0, wb_done = 1.
//  - in_ready = !hold_valid || last cycle, so accept and retire may coincide on one edge.
//  - Throughput: full 64-bit entry every 2 cycles; single-half or null entry every cycle.
//  - Idle outputs: wb_part, wb_register and wb_data are driven to 0; they never hold stale values.
//  - Latency: accept -> first write 1 cycle; accept -> done 1 cycle (single half) or 2 cycles (both).
//  - in_* are sampled only on accept. A held-but-unaccepted in_valid must keep its data stable (upstream duty).
//  - Reset (asynchronous, any time, including between halves):
//    hold_valid = 0, pend = 0, and the outputs (wb_*, wb_done) go to 0 immediately.
//    Any pending half is dropped, not completed. in_ready = 1 once reset is released.
// CONFIGURATION
//  CLARVI_WB_SKID_EN defined:
//  - A second entry is added behind the holding entry (2-deep FIFO, strict order).
//  - in_ready = !(both entries valid) || (holding entry in last cycle); no bubble between full entries.
//  - Emission is always from the head entry. Reset clears both entries.
//  CLARVI_WB_SKID_EN undefined: the single-entry behaviour above; no extra storage.
// TESTING
//  1. Assert reset_n = 0 mid-stream -> all wb_* = 0 and wb_done = 0 asynchronously.
//     After release, in_ready = 1 with no writes.
//  2. Accept reg 5, data 64'h1122334455667788, mask 11 at cycle 0:
//     c1: wb_enable = 1, part 0, reg 5, data 32'h55667788, in_ready = 0.
//     c2: part 1, data 32'h11223344, wb_done = 1, in_ready = 1.
//  3. Accept reg 7, mask 10, data 64'hDEADBEEF_00000000 -> c1: single write part 1, data 32'hDEADBEEF, wb_done = 1.
//  4. Accept reg 0, mask 11 (x0 suppression) -> c1: wb_enable = 0, wb_done = 1; no write in c1 or c2.
//  5. in_valid held with 3 full entries (regs 1, 2, 3):
//     - base config: accepts at c0/c2/c4; wb_enable high c1-c6; parts alternate 0,1; done at c2/c4/c6.
//     - with CLARVI_WB_SKID_EN: same write stream and no bubble.
//  6. reset_n pulsed low after the low-half write of reg 9 (mask 11) -> high half never written.
//     wb_done is not raised for reg 9.

Source files
------------

// File: rtl/clarvi_reg_writeback_if.sv
// Result hand-off (in_*) and register-file write port (wb_*) of clarvi_reg_writeback.
// master drives results and watches the write port; slave is the write-back sequencer.
interface clarvi_reg_writeback_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_register;
    logic [63:0] in_data;
    logic [1:0]  in_part_mask;
    logic        wb_enable;
    logic        wb_part;
    logic [4:0]  wb_register;
    logic [31:0] wb_data;
    logic        wb_done;

    modport master (
        output in_valid, in_register, in_data, in_part_mask,
        input  in_ready, wb_enable, wb_part, wb_register, wb_data, wb_done
    );

    modport slave (
        input  in_valid, in_register, in_data, in_part_mask,
        output in_ready, wb_enable, wb_part, wb_register, wb_data, wb_done
    );
endinterface

// File: rtl/clarvi_reg_writeback.sv
// clarvi_reg_writeback: serialises 64-bit results onto the 32-bit register-file write port, low half first.
// Define CLARVI_WB_SKID_EN to queue a second entry behind the holding entry (2-deep, strict order).
module clarvi_reg_writeback (
    input  logic                  clock,
    input  logic                  reset_n,
    clarvi_reg_writeback_if.slave bus
);

    typedef struct packed {
        logic        valid;
        logic [4:0]  idx;
        logic [63:0] data;
        logic [1:0]  pend;
    } entry_t;

    localparam entry_t EMPTY_ENTRY = '{valid: 1'b0, idx: 5'd0, data: 64'd0, pend: 2'b00};

    function automatic logic [1:0] effective_mask(input logic [4:0] idx, input logic [1:0] mask);
        logic [1:0] result;
        if (idx == 5'd0) begin
            result = 2'b00;
        end else begin
            result = mask;
        end
        return result;
    endfunction

    function automatic logic in_last_cycle(input entry_t e);
        return e.valid && (e.pend != 2'b11);
    endfunction

    function automatic logic [1:0] clear_emitted(input logic [1:0] pend);
        logic [1:0] result;
        if (pend[0]) begin
            result = {pend[1], 1'b0};
        end else begin
            result = 2'b00;
        end
        return result;
    endfunction

    function automatic logic [31:0] emitted_half(input entry_t e);
        logic [31:0] result;
        if (e.pend[0]) begin
            result = e.data[31:0];
        end else begin
            result = e.data[63:32];
        end
        return result;
    endfunction

    entry_t      head_r;
    entry_t      head_next_s;
    entry_t      in_entry_s;
    logic        accept_s;
    logic        retire_s;

    logic        wb_enable_r;
    logic        wb_part_r;
    logic [4:0]  wb_register_r;
    logic [31:0] wb_data_r;
    logic        wb_done_r;
    logic        in_ready_r;

    logic        wb_enable_next_s;
    logic        wb_part_next_s;
    logic [4:0]  wb_register_next_s;
    logic [31:0] wb_data_next_s;
    logic        wb_done_next_s;
    logic        in_ready_next_s;

`ifdef CLARVI_WB_SKID_EN
    entry_t      tail_r;
    entry_t      tail_next_s;
`endif

    // Handshake decode and the candidate entry built from the upstream result.
    always_comb begin
        accept_s   = bus.in_valid && in_ready_r;
        retire_s   = in_last_cycle(head_r);
        in_entry_s = '{valid: 1'b1,
                       idx:   bus.in_register,
                       data:  bus.in_data,
                       pend:  effective_mask(bus.in_register, bus.in_part_mask)};
    end

`ifdef CLARVI_WB_SKID_EN
    // Two-entry queue: the tail moves up as the head retires, so full entries stream without a bubble.
    always_comb begin
        head_next_s = head_r;
        tail_next_s = tail_r;
        if (retire_s) begin
            if (tail_r.valid) begin
                head_next_s = tail_r;
                if (accept_s) begin
                    tail_next_s = in_entry_s;
                end else begin
                    tail_next_s = EMPTY_ENTRY;
                end
            end else begin
                tail_next_s = EMPTY_ENTRY;
                if (accept_s) begin
                    head_next_s = in_entry_s;
                end else begin
                    head_next_s = EMPTY_ENTRY;
                end
            end
        end else if (head_r.valid) begin
            head_next_s.pend = clear_emitted(head_r.pend);
            if (accept_s) begin
                tail_next_s = in_entry_s;
            end else begin
                tail_next_s = tail_r;
            end
        end else begin
            tail_next_s = EMPTY_ENTRY;
            if (accept_s) begin
                head_next_s = in_entry_s;
            end else begin
                head_next_s = EMPTY_ENTRY;
            end
        end
    end
`else
    // Single holding entry: a new result can only land on the edge where the current one retires.
    always_comb begin
        head_next_s = head_r;
        if (retire_s) begin
            if (accept_s) begin
                head_next_s = in_entry_s;
            end else begin
                head_next_s = EMPTY_ENTRY;
            end
        end else if (head_r.valid) begin
            head_next_s.pend = clear_emitted(head_r.pend);
        end else if (accept_s) begin
            head_next_s = in_entry_s;
        end else begin
            head_next_s = EMPTY_ENTRY;
        end
    end
`endif

    // Write-port values for the next cycle, taken from whichever entry will sit at the head.
    always_comb begin
        wb_enable_next_s = head_next_s.valid && (head_next_s.pend != 2'b00);
        wb_done_next_s   = in_last_cycle(head_next_s);
        if (wb_enable_next_s) begin
            wb_part_next_s     = !head_next_s.pend[0];
            wb_register_next_s = head_next_s.idx;
            wb_data_next_s     = emitted_half(head_next_s);
        end else begin
            wb_part_next_s     = 1'b0;
            wb_register_next_s = 5'd0;
            wb_data_next_s     = 32'd0;
        end
`ifdef CLARVI_WB_SKID_EN
        in_ready_next_s = !(head_next_s.valid && tail_next_s.valid) || in_last_cycle(head_next_s);
`else
        in_ready_next_s = !head_next_s.valid || in_last_cycle(head_next_s);
`endif
    end

    // Entry storage and registered outputs; reset drops any half still pending.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_r        <= EMPTY_ENTRY;
`ifdef CLARVI_WB_SKID_EN
            tail_r        <= EMPTY_ENTRY;
`endif
            wb_enable_r   <= 1'b0;
            wb_part_r     <= 1'b0;
            wb_register_r <= 5'd0;
            wb_data_r     <= 32'd0;
            wb_done_r     <= 1'b0;
            in_ready_r    <= 1'b1;
        end else begin
            head_r        <= head_next_s;
`ifdef CLARVI_WB_SKID_EN
            tail_r        <= tail_next_s;
`endif
            wb_enable_r   <= wb_enable_next_s;
            wb_part_r     <= wb_part_next_s;
            wb_register_r <= wb_register_next_s;
            wb_data_r     <= wb_data_next_s;
            wb_done_r     <= wb_done_next_s;
            in_ready_r    <= in_ready_next_s;
        end
    end

    assign bus.in_ready    = in_ready_r;
    assign bus.wb_enable   = wb_enable_r;
    assign bus.wb_part     = wb_part_r;
    assign bus.wb_register = wb_register_r;
    assign bus.wb_data     = wb_data_r;
    assign bus.wb_done     = wb_done_r;

endmodule
